// File: rtl/core_sequencer.sv
// core_sequencer: runs one core program per start command.
// A run walks RESET (core held in reset) -> ARM -> RUN (core executing) -> DRAIN -> DONE.
// It ends with a result code on SEQ_STAT and a one-cycle SEQ_DONE pulse.
//
// Ports:
//   CCLK          clock, rising edge
//   CRST          asynchronous active-high reset
//   CMD_START     start request; accepted in IDLE/DONE when CMD_ABORT is low
//   CMD_ABORT     abort request; acts in RESET, ARM and RUN
//   CMD_ADDR      program base address, latched on an accepted start
//   CMD_LIMIT     RUN cycle budget, latched on an accepted start (0 = unlimited)
//   CORE_RST      core reset output
//   CORE_EXEC     core execute enable (high only in RUN)
//   CORE_MEM_ADDR latched program base address
//   CORE_STAT     core status; only the halt and error bits are used, and only in RUN
//   SEQ_STAT      result code: 0 idle, 1 busy, 2 halted, 3 error, 4 timeout, 5 aborted
//   SEQ_CYCLES    RUN cycles in the current or last run (saturating)
//   SEQ_BUSY      high outside IDLE and DONE
//   SEQ_DONE      one-cycle pulse on entry to DONE
module core_sequencer #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned HALT_BIT   = 0,
  parameter int unsigned ERR_BIT    = 1
) (
  input  logic        CCLK,
  input  logic        CRST,
  input  logic        CMD_START,
  input  logic        CMD_ABORT,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_LIMIT,
  output logic        CORE_RST,
  output logic        CORE_EXEC,
  output logic [31:0] CORE_MEM_ADDR,
  input  logic [7:0]  CORE_STAT,
  output logic [7:0]  SEQ_STAT,
  output logic [31:0] SEQ_CYCLES,
  output logic        SEQ_BUSY,
  output logic        SEQ_DONE
);

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StArm,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [2:0] CodeHalted  = 3'd2;
  localparam logic [2:0] CodeError   = 3'd3;
  localparam logic [2:0] CodeTimeout = 3'd4;
  localparam logic [2:0] CodeAborted = 3'd5;

  localparam logic [7:0] StatBusy    = 8'd1;
  localparam logic [7:0] StatAborted = 8'd5;

  localparam logic [7:0] RstLast = 8'(RST_CYCLES - 1);
  localparam logic [2:0] HaltIdx = 3'(HALT_BIT);
  localparam logic [2:0] ErrIdx  = 3'(ERR_BIT);

  state_e      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic        drain_cnt_q, drain_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] cycles_q, cycles_d;
  logic [7:0]  stat_q, stat_d;
  logic [2:0]  code_q, code_d;
  logic        done_q, done_d;

  logic        start_ok;
  logic [31:0] cycles_inc;
  logic [2:0]  run_code;

  assign start_ok   = CMD_START & ~CMD_ABORT;
  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;

  // RUN exit decision in priority order; 0 means keep running.
  always_comb begin
    run_code = 3'd0;
    if (CMD_ABORT) begin
      run_code = CodeAborted;
    end else if (CORE_STAT[ErrIdx]) begin
      run_code = CodeError;
    end else if (CORE_STAT[HaltIdx]) begin
      run_code = CodeHalted;
    end else if ((limit_q != 32'd0) && (cycles_inc == limit_q)) begin
      run_code = CodeTimeout;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    drain_cnt_d = drain_cnt_q;
    addr_d      = addr_q;
    limit_d     = limit_q;
    cycles_d    = cycles_q;
    stat_d      = stat_q;
    code_d      = code_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d   = StReset;
          rst_cnt_d = 8'd0;
          addr_d    = CMD_ADDR;
          limit_d   = CMD_LIMIT;
          cycles_d  = 32'd0;
          stat_d    = StatBusy;
        end
      end
      StReset: begin
        if (CMD_ABORT) begin
          state_d = StDone;
          stat_d  = StatAborted;
        end else if (rst_cnt_q == RstLast) begin
          state_d = StArm;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      StArm: begin
        if (CMD_ABORT) begin
          state_d = StDone;
          stat_d  = StatAborted;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        cycles_d = cycles_inc;
        if (run_code != 3'd0) begin
          state_d     = StDrain;
          code_d      = run_code;
          drain_cnt_d = 1'b0;
        end
      end
      StDrain: begin
        // Result stays hidden behind the busy code until DONE is entered.
        if (drain_cnt_q) begin
          state_d = StDone;
          stat_d  = {5'd0, code_q};
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign done_d = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      state_q     <= StIdle;
      rst_cnt_q   <= 8'd0;
      drain_cnt_q <= 1'b0;
      addr_q      <= 32'd0;
      limit_q     <= 32'd0;
      cycles_q    <= 32'd0;
      stat_q      <= 8'd0;
      code_q      <= 3'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      addr_q      <= addr_d;
      limit_q     <= limit_d;
      cycles_q    <= cycles_d;
      stat_q      <= stat_d;
      code_q      <= code_d;
      done_q      <= done_d;
    end
  end

  // Control outputs decode straight from the state so CRST takes effect without a clock.
  // An abort seen in ARM re-asserts core reset for that exit cycle.
  always_comb begin
    CORE_RST  = (state_q == StIdle) || (state_q == StReset) ||
                ((state_q == StArm) && CMD_ABORT);
    CORE_EXEC = (state_q == StRun);
    SEQ_BUSY  = (state_q != StIdle) && (state_q != StDone);
  end

  assign CORE_MEM_ADDR = addr_q;
  assign SEQ_STAT      = stat_q;
  assign SEQ_CYCLES    = cycles_q;
  assign SEQ_DONE      = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a run-timeline model.
module tb_core_sequencer;
  localparam int R = 4;

  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_ARM   = 2;
  localparam int P_RUN   = 3;
  localparam int P_DRAIN = 4;
  localparam int P_DONE  = 5;

  logic        CCLK = 1'b0;
  logic        CRST;
  logic        CMD_START, CMD_ABORT;
  logic [31:0] CMD_ADDR, CMD_LIMIT;
  logic        CORE_RST, CORE_EXEC;
  logic [31:0] CORE_MEM_ADDR;
  logic [7:0]  CORE_STAT;
  logic [7:0]  SEQ_STAT;
  logic [31:0] SEQ_CYCLES;
  logic        SEQ_BUSY, SEQ_DONE;

  always #5 CCLK = ~CCLK;

  core_sequencer #(.RST_CYCLES(R), .HALT_BIT(0), .ERR_BIT(1)) dut (
    .CCLK(CCLK), .CRST(CRST), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
    .CMD_ADDR(CMD_ADDR), .CMD_LIMIT(CMD_LIMIT), .CORE_RST(CORE_RST), .CORE_EXEC(CORE_EXEC),
    .CORE_MEM_ADDR(CORE_MEM_ADDR), .CORE_STAT(CORE_STAT), .SEQ_STAT(SEQ_STAT),
    .SEQ_CYCLES(SEQ_CYCLES), .SEQ_BUSY(SEQ_BUSY), .SEQ_DONE(SEQ_DONE)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a run is described by its age (cycles since the start was accepted, 1 = first
  // RESET cycle) and the age at which RUN decided to exit.
  bit          m_started, m_finished, m_done_pulse;
  int          m_age, m_exit_age, m_code;
  logic [31:0] m_addr, m_limit, m_cycles;
  logic [7:0]  m_stat;

  // Observations from the latest tick's sample point.
  logic [7:0]  obs_stat;
  logic [31:0] obs_cycles, obs_addr;
  logic        obs_done;
  int          cnt_exec, cnt_rst, cnt_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  function automatic int phase();
    if (!m_started) return P_IDLE;
    if (m_finished) return P_DONE;
    if (m_exit_age != 0) return P_DRAIN;
    if (m_age <= R) return P_RESET;
    if (m_age == R + 1) return P_ARM;
    return P_RUN;
  endfunction

  task automatic model_reset();
    m_started = 0; m_finished = 0; m_done_pulse = 0;
    m_age = 0; m_exit_age = 0; m_code = 0;
    m_addr = 0; m_limit = 0; m_cycles = 0; m_stat = 0;
  endtask

  task automatic model_finish(input int code);
    m_finished   = 1;
    m_stat       = 8'(code);
    m_done_pulse = 1;
  endtask

  // Advance the model by one clock using the inputs that were applied before the edge.
  task automatic model_step();
    int p;
    int code;
    p = phase();
    m_done_pulse = 0;
    case (p)
      P_IDLE, P_DONE: begin
        if (CMD_START && !CMD_ABORT) begin
          m_started = 1; m_finished = 0; m_age = 1; m_exit_age = 0;
          m_addr = CMD_ADDR; m_limit = CMD_LIMIT; m_cycles = 0; m_stat = 8'd1;
        end
      end
      P_RESET, P_ARM: begin
        if (CMD_ABORT) model_finish(5);
        else m_age++;
      end
      P_RUN: begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        code = 0;
        if (CMD_ABORT) code = 5;
        else if (CORE_STAT[1]) code = 3;
        else if (CORE_STAT[0]) code = 2;
        else if (m_limit != 0 && m_cycles == m_limit) code = 4;
        if (code != 0) begin
          m_exit_age = m_age;
          m_code = code;
        end
        m_age++;
      end
      default: begin
        m_age++;
        if (m_age - m_exit_age == 3) model_finish(m_code);
      end
    endcase
  endtask

  task automatic compare_outputs();
    int p;
    logic want_rst;
    p = phase();
    want_rst = (p == P_IDLE) || (p == P_RESET) || (p == P_ARM && CMD_ABORT);
    chk("core_rst", 32'(CORE_RST), 32'(want_rst));
    chk("core_exec", 32'(CORE_EXEC), 32'(p == P_RUN));
    chk("seq_busy", 32'(SEQ_BUSY), 32'(p != P_IDLE && p != P_DONE));
    chk("seq_done", 32'(SEQ_DONE), 32'(m_done_pulse));
    chk("seq_stat", 32'(SEQ_STAT), 32'(m_stat));
    chk("seq_cycles", SEQ_CYCLES, m_cycles);
    chk("core_mem_addr", CORE_MEM_ADDR, m_addr);
  endtask

  // One clock: apply inputs, compare at the falling edge, step the model after the rising edge.
  task automatic tick(input bit s, input bit a, input logic [31:0] ad, input logic [31:0] lim,
                      input logic [7:0] cs);
    CMD_START = s; CMD_ABORT = a; CMD_ADDR = ad; CMD_LIMIT = lim; CORE_STAT = cs;
    @(negedge CCLK);
    compare_outputs();
    obs_stat = SEQ_STAT; obs_cycles = SEQ_CYCLES; obs_addr = CORE_MEM_ADDR; obs_done = SEQ_DONE;
    if (CORE_EXEC) cnt_exec++;
    if (CORE_RST) cnt_rst++;
    if (SEQ_DONE) cnt_done++;
    @(posedge CCLK);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic clr();
    cnt_exec = 0; cnt_rst = 0; cnt_done = 0;
  endtask

  initial begin
    bit s, a;
    logic [31:0] lim;
    logic [7:0] cs;

    CRST = 1'b1; CMD_START = 0; CMD_ABORT = 0; CMD_ADDR = 0; CMD_LIMIT = 0; CORE_STAT = 0;
    model_reset();
    clr();
    @(negedge CCLK);
    chk("reset_core_rst", 32'(CORE_RST), 32'd1);
    chk("reset_core_exec", 32'(CORE_EXEC), 32'd0);
    chk("reset_seq_stat", 32'(SEQ_STAT), 32'd0);
    chk("reset_seq_busy", 32'(SEQ_BUSY), 32'd0);
    @(posedge CCLK);
    #1 CRST = 1'b0;
    idle(3);

    // Normal halt on the 10th RUN cycle.
    tick(1, 0, 32'h1000, 32'd0, 8'h00);
    clr();
    idle(5 + 9);
    tick(0, 0, 32'h0, 32'h0, 8'h01);
    idle(2);
    idle(1);
    chk("halt_stat", 32'(obs_stat), 32'd2);
    chk("halt_cycles", obs_cycles, 32'd10);
    chk("halt_done_pulse", 32'(obs_done), 32'd1);
    chk("halt_addr", obs_addr, 32'h1000);
    chk("halt_exec_cycles", cnt_exec, 10);
    chk("halt_rst_cycles", cnt_rst, R);
    idle(3);
    chk("halt_done_count", cnt_done, 1);

    // Timeout after 5 RUN cycles.
    tick(1, 0, 32'h3000, 32'd5, 8'h00);
    clr();
    idle(5 + 5 + 2 + 1);
    chk("timeout_stat", 32'(obs_stat), 32'd4);
    chk("timeout_cycles", obs_cycles, 32'd5);
    chk("timeout_exec_cycles", cnt_exec, 5);

    // Abort beats error beats halt.
    tick(1, 0, 32'h1000, 32'd0, 8'h00);
    idle(5 + 2);
    tick(0, 1, 32'h0, 32'h0, 8'h03);
    idle(3);
    chk("prio_abort_stat", 32'(obs_stat), 32'd5);
    chk("prio_abort_cycles", obs_cycles, 32'd3);

    tick(1, 0, 32'h1000, 32'd0, 8'h00);
    idle(5 + 2);
    tick(0, 0, 32'h0, 32'h0, 8'h03);
    idle(3);
    chk("prio_err_stat", 32'(obs_stat), 32'd3);

    // Halt beats the limit on the cycle the limit is reached.
    tick(1, 0, 32'h1000, 32'd3, 8'h00);
    idle(5 + 2);
    tick(0, 0, 32'h0, 32'h0, 8'h01);
    idle(3);
    chk("prio_halt_stat", 32'(obs_stat), 32'd2);
    chk("prio_halt_cycles", obs_cycles, 32'd3);

    // Start during RUN is ignored.
    tick(1, 0, 32'h1000, 32'd6, 8'h00);
    idle(5 + 1);
    tick(1, 0, 32'h2000, 32'd0, 8'h00);
    idle(4);
    chk("ign_addr_run", obs_addr, 32'h1000);
    idle(3);
    chk("ign_stat", 32'(obs_stat), 32'd4);
    chk("ign_cycles", obs_cycles, 32'd6);
    chk("ign_addr_done", obs_addr, 32'h1000);

    // Abort in the 2nd RESET cycle.
    tick(1, 0, 32'h4000, 32'd0, 8'h00);
    clr();
    idle(1);
    tick(0, 1, 32'h0, 32'h0, 8'h00);
    idle(1);
    chk("early_stat", 32'(obs_stat), 32'd5);
    chk("early_cycles", obs_cycles, 32'd0);
    chk("early_done_pulse", 32'(obs_done), 32'd1);
    chk("early_exec_cycles", cnt_exec, 0);

    // Asynchronous reset in the middle of RUN, between clock edges.
    tick(1, 0, 32'h1000, 32'd0, 8'h00);
    idle(5 + 3);
    #2 CRST = 1'b1;
    #1;
    chk("async_core_exec", 32'(CORE_EXEC), 32'd0);
    chk("async_core_rst", 32'(CORE_RST), 32'd1);
    chk("async_addr", CORE_MEM_ADDR, 32'd0);
    chk("async_stat", 32'(SEQ_STAT), 32'd0);
    chk("async_cycles", SEQ_CYCLES, 32'd0);
    chk("async_busy", 32'(SEQ_BUSY), 32'd0);
    chk("async_done", 32'(SEQ_DONE), 32'd0);
    #1 CRST = 1'b0;
    model_reset();
    clr();
    idle(10);
    chk("async_no_done", cnt_done, 0);
    chk("async_idle_rst", cnt_rst, 10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s   = ($urandom_range(0, 5) == 0);
      a   = ($urandom_range(0, 29) == 0);
      lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      cs  = 8'($urandom);
      cs[0] = ($urandom_range(0, 11) == 0);
      cs[1] = ($urandom_range(0, 19) == 0);
      tick(s, a, $urandom, lim, cs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
